calc_key_sequencer: RTL and testbench

- Sequences the calculator datapath from keyboard scan-code bytes produced by the PS/2 receiver (one byte per rx_valid strobe).
- Filters break (F0) and extended (E0) prefixes, builds decimal operands, latches the operator, and issues operations to the arithmetic unit over a req/ack handshake.
- Drives the display value and the error/busy status to the top level.

---
 rtl/calc_key_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_calc_key_sequencer.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/calc_key_sequencer.sv
// rtl/calc_key_sequencer.sv - scan-code driven calculator sequencer with ALU req/ack handshake
// Optional build macro SIGNED_ENTRY_EN: leading '-' toggles the sign of the operand being entered.
module calc_key_sequencer #(
  parameter int W          = 32,
  parameter int MAX_DIGITS = 4,
  parameter int TIMEOUT    = 1024
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         rx_valid,
  input  logic [7:0]   rx_byte,
  output logic         alu_req,
  output logic [1:0]   alu_op,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  input  logic         alu_ack,
  input  logic [W-1:0] alu_result,
  input  logic         alu_err,
  output logic [W-1:0] disp_value,
  output logic         disp_is_result,
  output logic         err,
  output logic         busy
);

  localparam int CW = $clog2(MAX_DIGITS + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {S_A, S_B, S_ISSUE, S_SHOW, S_ERR} state_t;

  state_t         state;
  logic [W-1:0]   a, b;
  logic [CW-1:0]  cnt;
  logic [1:0]     op, pending_op;
  logic           chain, brk, ext, sign_a, sign_b;
  logic [TW-1:0]  timer;

  logic           is_digit, is_op, is_enter, is_esc, is_bksp;
  logic [3:0]     digit;
  logic [1:0]     key_op;
  logic           is_prefix, key_ev, minus_toggle, op_key, room;
  logic [W-1:0]   a_next, b_next;

  function automatic logic [W-1:0] signed_val(input logic s, input logic [W-1:0] v);
    return s ? -v : v;
  endfunction

  always_comb begin
    is_digit = 1'b0;
    digit    = 4'd0;
    is_op    = 1'b0;
    key_op   = 2'b00;
    is_enter = 1'b0;
    is_esc   = 1'b0;
    is_bksp  = 1'b0;
    case (rx_byte)
      8'h70: begin is_digit = 1'b1; digit = 4'd0; end
      8'h69: begin is_digit = 1'b1; digit = 4'd1; end
      8'h72: begin is_digit = 1'b1; digit = 4'd2; end
      8'h7A: begin is_digit = 1'b1; digit = 4'd3; end
      8'h6B: begin is_digit = 1'b1; digit = 4'd4; end
      8'h73: begin is_digit = 1'b1; digit = 4'd5; end
      8'h74: begin is_digit = 1'b1; digit = 4'd6; end
      8'h6C: begin is_digit = 1'b1; digit = 4'd7; end
      8'h75: begin is_digit = 1'b1; digit = 4'd8; end
      8'h7D: begin is_digit = 1'b1; digit = 4'd9; end
      8'h79: begin is_op = 1'b1; key_op = 2'b00; end
      8'h7B: begin is_op = 1'b1; key_op = 2'b01; end
      8'h7C: begin is_op = 1'b1; key_op = 2'b10; end
      8'h4A: begin is_op = ext; key_op = 2'b11; end
      8'h5A: is_enter = 1'b1;
      8'h76: is_esc = 1'b1;
      8'h66: is_bksp = 1'b1;
      default: ;
    endcase
  end

  assign is_prefix = (rx_byte == 8'hF0) || (rx_byte == 8'hE0);
  assign key_ev    = rx_valid && !is_prefix && !brk;
  assign room      = cnt < CW'(MAX_DIGITS);
  assign a_next    = a * W'(10) + W'(digit);
  assign b_next    = b * W'(10) + W'(digit);

`ifdef SIGNED_ENTRY_EN
  assign minus_toggle = is_op && (key_op == 2'b01) && (cnt == '0) &&
                        ((state == S_A) || (state == S_B));
`else
  assign minus_toggle = 1'b0;
`endif
  assign op_key = is_op && !minus_toggle;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_A;  a <= '0;  b <= '0;  cnt <= '0;
      op <= 2'b00;  pending_op <= 2'b00;  chain <= 1'b0;
      brk <= 1'b0;  ext <= 1'b0;  sign_a <= 1'b0;  sign_b <= 1'b0;
      timer <= '0;  alu_req <= 1'b0;  alu_op <= 2'b00;  alu_a <= '0;  alu_b <= '0;
      disp_value <= '0;  disp_is_result <= 1'b0;  err <= 1'b0;  busy <= 1'b0;
    end else begin
      // The prefix filter runs in every state so a break byte seen while busy is still honoured.
      if (rx_valid) begin
        if (rx_byte == 8'hF0)      brk <= 1'b1;
        else if (rx_byte == 8'hE0) ext <= 1'b1;
        else begin brk <= 1'b0; ext <= 1'b0; end
      end

      if (key_ev && is_esc && state != S_ISSUE) begin
        state <= S_A;  a <= '0;  b <= '0;  cnt <= '0;
        sign_a <= 1'b0;  sign_b <= 1'b0;
        err <= 1'b0;  disp_value <= '0;  disp_is_result <= 1'b0;
      end else begin
        case (state)
          S_A: if (key_ev) begin
            if (is_digit && room) begin
              a <= a_next;  cnt <= cnt + CW'(1);
              disp_value <= signed_val(sign_a, a_next);  disp_is_result <= 1'b0;
            end else if (is_bksp) begin
              a <= '0;  cnt <= '0;  sign_a <= 1'b0;
              disp_value <= '0;  disp_is_result <= 1'b0;
            end else if (minus_toggle) begin
              sign_a <= ~sign_a;
            end else if (op_key) begin
              op <= key_op;  b <= '0;  cnt <= '0;  sign_b <= 1'b0;  state <= S_B;
            end else if (is_enter) begin
              disp_value <= signed_val(sign_a, a);  disp_is_result <= 1'b0;
            end
          end
          S_B: if (key_ev) begin
            if (is_digit && room) begin
              b <= b_next;  cnt <= cnt + CW'(1);
              disp_value <= signed_val(sign_b, b_next);  disp_is_result <= 1'b0;
            end else if (is_bksp) begin
              b <= '0;  cnt <= '0;  sign_b <= 1'b0;
              disp_value <= '0;  disp_is_result <= 1'b0;
            end else if (minus_toggle) begin
              sign_b <= ~sign_b;
            end else if (op_key && cnt == '0) begin
              op <= key_op;
            end else if ((op_key || is_enter) && cnt != '0) begin
              // Operands are committed here so they are stable a cycle before alu_req rises.
              alu_a <= signed_val(sign_a, a);  alu_b <= signed_val(sign_b, b);
              alu_op <= op;  chain <= op_key;  pending_op <= key_op;
              busy <= 1'b1;  state <= S_ISSUE;
            end
          end
          S_ISSUE: begin
            if (!alu_req) begin
              alu_req <= 1'b1;  timer <= '0;
            end else if (alu_ack) begin
              alu_req <= 1'b0;  busy <= 1'b0;
              if (alu_err) begin
                state <= S_ERR;  err <= 1'b1;  disp_value <= '0;  disp_is_result <= 1'b0;
              end else begin
                a <= alu_result;  sign_a <= 1'b0;
                disp_value <= alu_result;  disp_is_result <= 1'b1;
                if (chain) begin
                  op <= pending_op;  b <= '0;  cnt <= '0;  sign_b <= 1'b0;  state <= S_B;
                end else begin
                  state <= S_SHOW;
                end
              end
            end else if (timer == TW'(TIMEOUT - 1)) begin
              alu_req <= 1'b0;  busy <= 1'b0;  state <= S_ERR;
              err <= 1'b1;  disp_value <= '0;  disp_is_result <= 1'b0;
            end else begin
              timer <= timer + TW'(1);
            end
          end
          S_SHOW: if (key_ev) begin
            if (is_digit) begin
              a <= W'(digit);  cnt <= CW'(1);  sign_a <= 1'b0;
              disp_value <= W'(digit);  disp_is_result <= 1'b0;  state <= S_A;
            end else if (is_op) begin
              op <= key_op;  b <= '0;  cnt <= '0;  sign_b <= 1'b0;  state <= S_B;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_calc_key_sequencer.sv
// tb/tb_calc_key_sequencer.sv - table-driven bench for calc_key_sequencer
module tb_calc_key_sequencer;

  localparam int K_RAW = 0, K_KEY = 1, K_XKEY = 2, K_ACK = 3, K_AERR = 4;

  typedef struct {
    int          kind;
    logic [31:0] val;
    logic        req;
    logic [31:0] ea, eb;
    logic [1:0]  eop;
    logic [31:0] disp;
    logic        dir, err, busy;
  } vec_t;

  logic        clk = 1'b0, rst = 1'b0, rx_valid = 1'b0, alu_ack = 1'b0, alu_err = 1'b0;
  logic [7:0]  rx_byte = 8'h00;
  logic [31:0] alu_result = '0;
  logic        alu_req, disp_is_result, err, busy;
  logic [1:0]  alu_op;
  logic [31:0] alu_a, alu_b, disp_value;

  int total = 0, bad = 0;
  vec_t tv[$];

  calc_key_sequencer dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_byte(rx_byte),
    .alu_req(alu_req), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_ack(alu_ack), .alu_result(alu_result), .alu_err(alu_err),
    .disp_value(disp_value), .disp_is_result(disp_is_result), .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic add(input int kind, input logic [31:0] val, input logic req,
                     input logic [31:0] ea, input logic [31:0] eb, input logic [1:0] eop,
                     input logic [31:0] disp, input logic dir, input logic er, input logic bsy);
    vec_t v;
    v.kind = kind; v.val = val; v.req = req; v.ea = ea; v.eb = eb; v.eop = eop;
    v.disp = disp; v.dir = dir; v.err = er; v.busy = bsy;
    tv.push_back(v);
  endtask

  task automatic settle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_valid = 1'b1; rx_byte = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic press(input logic [7:0] code, input logic x);
    if (x) send_byte(8'hE0);
    send_byte(code);
    if (x) send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(code);
    settle(2);
  endtask

  task automatic do_ack(input logic [31:0] res, input logic e);
    int n = 0;
    while (!alu_req && n < 50) begin @(negedge clk); n++; end
    if (!alu_req) check("ack_wait_req", {31'd0, alu_req}, 32'd1);
    @(negedge clk);
    alu_ack = 1'b1; alu_result = res; alu_err = e;
    @(negedge clk);
    alu_ack = 1'b0; alu_err = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int hi;
    // Filtering: only 79 (+) and 5A (Enter, ignored with empty B) are keys here.
    foreach (tv[i]) ;
    add(K_RAW, 8'h16, 0, 0, 0, 0, 0, 0, 0, 0);
    add(K_RAW, 8'hF0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(K_RAW, 8'h16, 0, 0, 0, 0, 0, 0, 0, 0);
    add(K_RAW, 8'h1E, 0, 0, 0, 0, 0, 0, 0, 0);
    add(K_RAW, 8'hF0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(K_RAW, 8'h1E, 0, 0, 0, 0, 0, 0, 0, 0);
    add(K_RAW, 8'h79, 0, 0, 0, 0, 0, 0, 0, 0);
    add(K_RAW, 8'hF0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(K_RAW, 8'h79, 0, 0, 0, 0, 0, 0, 0, 0);
    add(K_RAW, 8'h26, 0, 0, 0, 0, 0, 0, 0, 0);
    add(K_RAW, 8'hF0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(K_RAW, 8'h26, 0, 0, 0, 0, 0, 0, 0, 0);
    add(K_RAW, 8'h5A, 0, 0, 0, 0, 0, 0, 0, 0);
    add(K_KEY, 8'h76, 0, 0, 0, 0, 0, 0, 0, 0);
    // 12 + 3
    add(K_KEY, 8'h69, 0, 0, 0, 0, 1, 0, 0, 0);
    add(K_KEY, 8'h72, 0, 0, 0, 0, 12, 0, 0, 0);
    add(K_KEY, 8'h79, 0, 0, 0, 0, 12, 0, 0, 0);
    add(K_KEY, 8'h7A, 0, 0, 0, 0, 3, 0, 0, 0);
    add(K_KEY, 8'h5A, 1, 12, 3, 2'b00, 3, 0, 0, 1);
    add(K_ACK, 15, 0, 0, 0, 0, 15, 1, 0, 0);
    // digit limit and backspace
    add(K_KEY, 8'h69, 0, 0, 0, 0, 1, 0, 0, 0);
    add(K_KEY, 8'h72, 0, 0, 0, 0, 12, 0, 0, 0);
    add(K_KEY, 8'h7A, 0, 0, 0, 0, 123, 0, 0, 0);
    add(K_KEY, 8'h6B, 0, 0, 0, 0, 1234, 0, 0, 0);
    add(K_KEY, 8'h73, 0, 0, 0, 0, 1234, 0, 0, 0);
    add(K_KEY, 8'h66, 0, 0, 0, 0, 0, 0, 0, 0);
    // chain: 7 * 6 - 2
    add(K_KEY, 8'h6C, 0, 0, 0, 0, 7, 0, 0, 0);
    add(K_KEY, 8'h7C, 0, 0, 0, 0, 7, 0, 0, 0);
    add(K_KEY, 8'h74, 0, 0, 0, 0, 6, 0, 0, 0);
    add(K_KEY, 8'h7B, 1, 7, 6, 2'b10, 6, 0, 0, 1);
    add(K_ACK, 42, 0, 0, 0, 0, 42, 1, 0, 0);
    add(K_KEY, 8'h72, 0, 0, 0, 0, 2, 0, 0, 0);
    add(K_KEY, 8'h5A, 1, 42, 2, 2'b01, 2, 0, 0, 1);
    add(K_ACK, 40, 0, 0, 0, 0, 40, 1, 0, 0);
    // 8 / 0 with ALU fault, keys locked out until Esc
    add(K_KEY, 8'h75, 0, 0, 0, 0, 8, 0, 0, 0);
    add(K_XKEY, 8'h4A, 0, 0, 0, 0, 8, 0, 0, 0);
    add(K_KEY, 8'h70, 0, 0, 0, 0, 0, 0, 0, 0);
    add(K_KEY, 8'h5A, 1, 8, 0, 2'b11, 0, 0, 0, 1);
    add(K_AERR, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    add(K_KEY, 8'h69, 0, 0, 0, 0, 0, 0, 1, 0);
    add(K_KEY, 8'h76, 0, 0, 0, 0, 0, 0, 0, 0);

    settle(3);
    check("rst_req", {31'd0, alu_req}, 0);
    check("rst_disp", disp_value, 0);
    check("rst_busy_err_dir", {29'd0, busy, err, disp_is_result}, 0);
    check("rst_ab_op", alu_a | alu_b | {30'd0, alu_op}, 0);
    @(negedge clk);
    rst = 1'b1;
    settle(2);

    for (int i = 0; i < tv.size(); i++) begin
      case (tv[i].kind)
        K_RAW:  begin send_byte(tv[i].val[7:0]); settle(2); end
        K_KEY:  press(tv[i].val[7:0], 1'b0);
        K_XKEY: press(tv[i].val[7:0], 1'b1);
        default: do_ack(tv[i].val, tv[i].kind == K_AERR);
      endcase
      check($sformatf("v%0d.req", i), {31'd0, alu_req}, {31'd0, tv[i].req});
      check($sformatf("v%0d.disp", i), disp_value, tv[i].disp);
      check($sformatf("v%0d.dir", i), {31'd0, disp_is_result}, {31'd0, tv[i].dir});
      check($sformatf("v%0d.err", i), {31'd0, err}, {31'd0, tv[i].err});
      check($sformatf("v%0d.busy", i), {31'd0, busy}, {31'd0, tv[i].busy});
      if (tv[i].req) begin
        check($sformatf("v%0d.a", i), alu_a, tv[i].ea);
        check($sformatf("v%0d.b", i), alu_b, tv[i].eb);
        check($sformatf("v%0d.op", i), {30'd0, alu_op}, {30'd0, tv[i].eop});
      end
    end

    // ALU never answers: request held exactly TIMEOUT cycles, then error
    press(8'h69, 1'b0);
    press(8'h79, 1'b0);
    press(8'h72, 1'b0);
    send_byte(8'h5A);
    hi = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (alu_req) hi++;
      else if (hi > 0) break;
    end
    check("timeout_len", hi, 1024);
    check("timeout_err", {31'd0, err}, 1);
    check("timeout_req", {31'd0, alu_req}, 0);
    check("timeout_disp", disp_value, 0);
    @(negedge clk);
    alu_ack = 1'b1; alu_result = 99;
    @(negedge clk);
    alu_ack = 1'b0;
    settle(1);
    check("late_ack_disp", disp_value, 0);
    check("late_ack_err", {31'd0, err}, 1);
    press(8'h76, 1'b0);
    check("esc_clears_err", {31'd0, err}, 0);

    // Reset in the middle of a handshake
    press(8'h69, 1'b0);
    press(8'h79, 1'b0);
    press(8'h72, 1'b0);
    press(8'h5A, 1'b0);
    check("pre_rst_req", {31'd0, alu_req}, 1);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("async_rst_req", {31'd0, alu_req}, 0);
    check("async_rst_busy", {31'd0, busy}, 0);
    check("async_rst_a", alu_a, 0);
    alu_ack = 1'b1; alu_result = 77;
    @(negedge clk);
    alu_ack = 1'b0;
    rst = 1'b1;
    settle(2);
    check("post_rst_disp", disp_value, 0);
    check("post_rst_dir", {31'd0, disp_is_result}, 0);
    press(8'h6B, 1'b0);
    check("post_rst_state_a", disp_value, 4);
    check("post_rst_req", {31'd0, alu_req}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
